// File: rtl/sqrt_result_bcd.sv
// Captures root/remainder from the square-root unit and converts both to packed BCD
// with a shared sequential double-dabble engine, one bit per clock.
module sqrt_result_bcd #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      root,
  input  logic [WIDTH-1:0]      rem,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   root_bcd,
  output logic [4*DIGITS-1:0]   rem_bcd,
  output logic                  overrun
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned SW = BW + WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  state_e          r_state;
  logic            r_in_valid_d;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_root_sh;
  logic [SW-1:0]   r_rem_sh;
  logic            r_busy;
  logic            r_out_valid;
  logic            r_overrun;
  logic [BW-1:0]   r_root_bcd;
  logic [BW-1:0]   r_rem_bcd;

  logic            w_capture;
  logic [SW-1:0]   w_root_nxt;
  logic [SW-1:0]   w_rem_nxt;

  // One double-dabble step: correct every BCD nibble using its pre-shift value, then shift.
  function automatic logic [SW-1:0] dabble(input logic [SW-1:0] v);
    logic [SW-1:0] t;
    t = v;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (t[WIDTH+4*d +: 4] >= 4'd5) t[WIDTH+4*d +: 4] = t[WIDTH+4*d +: 4] + 4'd3;
    end
    return {t[SW-2:0], 1'b0};
  endfunction

  assign w_capture  = in_valid & ~r_in_valid_d;
  assign w_root_nxt = dabble(r_root_sh);
  assign w_rem_nxt  = dabble(r_rem_sh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_in_valid_d <= 1'b0;
      r_cnt        <= '0;
      r_root_sh    <= '0;
      r_rem_sh     <= '0;
      r_busy       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_overrun    <= 1'b0;
      r_root_bcd   <= '0;
      r_rem_bcd    <= '0;
    end else begin
      r_in_valid_d <= in_valid;
      unique case (r_state)
        StIdle: begin
          if (w_capture) begin
            r_root_sh <= {{BW{1'b0}}, root};
            r_rem_sh  <= {{BW{1'b0}}, rem};
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= StShift;
          end
        end
        StShift: begin
          r_root_sh <= w_root_nxt;
          r_rem_sh  <= w_rem_nxt;
          r_cnt     <= r_cnt + CW'(1);
          if (w_capture) r_overrun <= 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_root_bcd  <= w_root_nxt[SW-1 -: BW];
            r_rem_bcd   <= w_rem_nxt[SW-1 -: BW];
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= StHold;
          end
        end
        StHold: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            // Handshake and a new result on the same clock chain straight into conversion.
            if (w_capture) begin
              r_root_sh <= {{BW{1'b0}}, root};
              r_rem_sh  <= {{BW{1'b0}}, rem};
              r_cnt     <= '0;
              r_busy    <= 1'b1;
              r_state   <= StShift;
            end else begin
              r_state <= StIdle;
            end
          end else if (w_capture) begin
            r_overrun <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign root_bcd  = r_root_bcd;
  assign rem_bcd   = r_rem_bcd;

endmodule

// File: doc/sqrt_result_bcd.md
Name: sqrt_result_bcd

Overview:
Downstream stage of the iterative square-root unit. It captures the 8-bit root and remainder when the root unit raises its level-held valid flag. It converts both values to packed BCD using a sequential shift-add-3 (double-dabble) engine, one bit per clock. It presents the digits to the display/readout logic over a valid/ready handshake.

Parameters:
WIDTH, 8, binary width of root and remainder inputs; also the number of conversion iterations.
DIGITS, 3, number of BCD digits per value; 10^DIGITS must exceed 2^WIDTH-1.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  level valid from root unit; a new result is signalled by its rising edge
root  input  WIDTH  binary root, sampled at capture
rem  input  WIDTH  binary remainder, sampled at capture
busy  output  1  high while converting (state SHIFT)
out_valid  output  1  BCD results valid (state HOLD)
out_ready  input  1  consumer accepts results
root_bcd  output  4*DIGITS  packed BCD of root, digit 0 in [3:0]
rem_bcd  output  4*DIGITS  packed BCD of remainder
overrun  output  1  sticky: a new result arrived while the block was not idle

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. busy, out_valid, overrun, root_bcd, rem_bcd, the iteration counter and the edge-detect register in_valid_d all go to 0.
- Edge detect: capture = in_valid & ~in_valid_d. in_valid_d is registered every cycle. Because in_valid_d resets to 0, in_valid held high out of reset counts as an edge on the first clock.
- IDLE:
  - On a clock with capture=1, load the root shifter with {4*DIGITS zeros, root} and the rem shifter with {4*DIGITS zeros, rem}, clear the counter, and go to SHIFT.
  - When capture=0, remain in IDLE.
- SHIFT (busy=1):
  - Each clock, on both shifters in parallel: every BCD nibble >=5 gets +3, then the whole register shifts left by 1.
  - The counter increments each clock. On the clock that completes iteration WIDTH-1, copy the BCD fields into root_bcd/rem_bcd and go to HOLD.
  - Latency: capture at edge N gives out_valid high after edge N+WIDTH (8 clocks for the default).
- HOLD (out_valid=1):
  - root_bcd and rem_bcd stay stable until the handshake completes.
  - If out_ready=1 and capture=0: go to IDLE; out_valid=0 from the next cycle.
  - If out_ready=1 and capture=1 on the same clock: accept the result and load the new operands directly into SHIFT. This is not an overrun.
- Overrun: capture=1 in SHIFT, or capture=1 in HOLD with out_ready=0, sets overrun=1. The new operands are discarded and the in-flight or held result is unaffected. overrun clears only on reset.
- root_bcd/rem_bcd keep their last values outside HOLD. Only out_valid qualifies them.
- Reset mid-SHIFT or mid-HOLD aborts the conversion immediately with no output. After release, a still-high in_valid is re-captured per the edge-detect rule.
- Width rule: each shifter is 4*DIGITS+WIDTH bits. The add-3 check uses the nibble value before the shift. No arithmetic overflows for legal parameters.

Test Plan:
1. root=15, rem=6 (rad=231), in_valid rises and holds, out_ready=1 -> busy for 8 cycles; out_valid after edge N+8; root_bcd=12'h015, rem_bcd=12'h006; returns to IDLE next cycle; no second capture while in_valid stays high.
2. root=255, rem=30 -> root_bcd=12'h255, rem_bcd=12'h030. Then root=0, rem=0 -> both 12'h000.
3. Backpressure: result in HOLD with out_ready=0 for 5 cycles -> out_valid, root_bcd and rem_bcd stable throughout. Raise out_ready -> out_valid drops the following cycle.
4. Overrun: second in_valid rising edge at SHIFT cycle 3 (root=9) -> overrun=1 sticky; the first result still delivered correctly; root=9 never appears.
5. Simultaneous: in HOLD, out_ready=1 and a new rising edge (root=100, rem=12) on the same clock -> goes straight to SHIFT; overrun stays 0; next result 12'h100 / 12'h012.
6. Reset: assert rst_n=0 at SHIFT cycle 4 -> all outputs 0 immediately. Release with in_valid high (root=42, rem=5) -> recaptured; result 12'h042 / 12'h005.
